// File: rtl/reg_sequencer.sv
// Byte-stream instruction sequencer that drives per-register strobes into an external register bank.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: an illegal opcode sets the sticky illegal flag and halts.
//
// state | meaning
// FETCH | accept an opcode byte
// IMM   | accept the MVI immediate byte
// EXEC  | one-cycle strobe to the bank, then back to FETCH
// HALT  | absorbing until rst
module reg_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  input  logic [7:0] rd_data,
  output logic [2:0] rd_sel,
  output logic [7:0] load,
  output logic [7:0] inr,
  output logic [7:0] dcr,
  output logic [7:0] data_out,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] retired
);

  typedef enum logic [1:0] {FETCH, IMM, EXEC, HALT} state_t;
  typedef enum logic [2:0] {K_NOP, K_INR, K_DCR, K_MVI, K_MOV} kind_t;

  state_t     state, state_nxt;
  kind_t      kind, kind_nxt, dec_kind;
  logic [2:0] dst, dst_nxt, src, src_nxt;
  logic [7:0] imm, imm_nxt, retired_q, retired_nxt;
  logic       dec_legal, dec_hlt;

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_set;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign retired = retired_q;
  assign rd_sel  = src;
  assign halted  = (state == HALT);

  // HLT is 8'h76 and must win over MOV 6,6, so it is tested first.
  always_comb begin
    dec_kind  = K_NOP;
    dec_legal = 1'b1;
    dec_hlt   = 1'b0;
    if (instr_data == 8'h00)
      dec_kind = K_NOP;
    else if (instr_data == 8'h76)
      dec_hlt = 1'b1;
    else if (instr_data[7:6] == 2'b01)
      dec_kind = K_MOV;
    else if (instr_data[7:6] == 2'b00 && instr_data[2:0] == 3'b100)
      dec_kind = K_INR;
    else if (instr_data[7:6] == 2'b00 && instr_data[2:0] == 3'b101)
      dec_kind = K_DCR;
    else if (instr_data[7:6] == 2'b00 && instr_data[2:0] == 3'b110)
      dec_kind = K_MVI;
    else
      dec_legal = 1'b0;
  end

  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind;
    dst_nxt     = dst;
    src_nxt     = src;
    imm_nxt     = imm;
    retired_nxt = retired_q;
    instr_ready = 1'b0;
    load        = 8'h00;
    inr         = 8'h00;
    dcr         = 8'h00;
    data_out    = 8'h00;
`ifdef SEQ_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    unique case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (dec_hlt) begin
            state_nxt   = HALT;
            retired_nxt = retired_q + 8'd1;
          end else if (!dec_legal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_set = 1'b1;
            state_nxt   = HALT;
`endif
          end else begin
            kind_nxt = dec_kind;
            dst_nxt  = instr_data[5:3];
            if (dec_kind == K_MOV) src_nxt = instr_data[2:0];
            state_nxt = (dec_kind == K_MVI) ? IMM : EXEC;
          end
        end
      end
      IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          imm_nxt   = instr_data;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        retired_nxt = retired_q + 8'd1;
        state_nxt   = FETCH;
        case (kind)
          K_MVI: begin
            load     = 8'h01 << dst;
            data_out = imm;
          end
          K_MOV: begin
            load     = 8'h01 << dst;
            data_out = rd_data;
          end
          K_INR:   inr = 8'h01 << dst;
          K_DCR:   dcr = 8'h01 << dst;
          default: ;
        endcase
      end
      HALT:    ;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      kind      <= K_NOP;
      dst       <= 3'd0;
      src       <= 3'd0;
      imm       <= 8'h00;
      retired_q <= 8'h00;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      kind      <= kind_nxt;
      dst       <= dst_nxt;
      src       <= src_nxt;
      imm       <= imm_nxt;
      retired_q <= retired_nxt;
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (illegal_set) illegal_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed self-checking bench for reg_sequencer; inputs change on the falling edge, outputs sampled 1 ns later.
module tb_reg_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic       instr_ready;
  logic [7:0] rd_data = 8'h00;
  logic [2:0] rd_sel;
  logic [7:0] load, inr, dcr, data_out, retired;
  logic       halted, illegal;
  int n_cmp = 0;
  int n_err = 0;

  reg_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .rd_data(rd_data), .rd_sel(rd_sel),
    .load(load), .inr(inr), .dcr(dcr), .data_out(data_out),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0;
    adv();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; instr_data = 8'h76;
    adv();
    rst = 1'b0; instr_valid = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b exp 0", halted); end
    n_cmp++; if (retired !== 8'h00) begin n_err++; $display("FAIL reset_retired: got %h exp 00", retired); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b exp 0", illegal); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", instr_ready); end
    n_cmp++; if ({load, inr, dcr, data_out} !== 32'h0) begin n_err++; $display("FAIL reset_strobes: got %h exp 0", {load, inr, dcr, data_out}); end
    n_cmp++; if (rd_sel !== 3'd0) begin n_err++; $display("FAIL reset_rd_sel: got %0d exp 0", rd_sel); end
  endtask

  task automatic test_mvi();
    do_reset();
    instr_valid = 1'b1; instr_data = 8'h0E;
    #1;
    n_cmp++; if (load !== 8'h00) begin n_err++; $display("FAIL mvi_fetch_load: got %h exp 00", load); end
    adv();
    instr_data = 8'h5A;
    #1;
    n_cmp++; if (instr_ready !== 1'b1 || load !== 8'h00) begin n_err++; $display("FAIL mvi_imm: got ready=%b load=%h exp 1/00", instr_ready, load); end
    adv();
    instr_valid = 1'b0;
    #1;
    n_cmp++; if (load !== 8'h02) begin n_err++; $display("FAIL mvi_load: got %h exp 02", load); end
    n_cmp++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL mvi_data: got %h exp 5a", data_out); end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL mvi_exec_ready: got %b exp 0", instr_ready); end
    adv();
    n_cmp++; if (load !== 8'h00 || data_out !== 8'h00) begin n_err++; $display("FAIL mvi_after: got load=%h data=%h exp 00/00", load, data_out); end
    n_cmp++; if (retired !== 8'h01) begin n_err++; $display("FAIL mvi_retired: got %h exp 01", retired); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr_valid = 1'b1; instr_data = 8'h04;
    adv();
    instr_data = 8'h2D;
    #1;
    n_cmp++; if (inr !== 8'h01 || dcr !== 8'h00 || load !== 8'h00) begin n_err++; $display("FAIL b2b_inr: got inr=%h dcr=%h load=%h exp 01/00/00", inr, dcr, load); end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_exec1: got %b exp 0", instr_ready); end
    adv();
    n_cmp++; if (inr !== 8'h00 || instr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_fetch2: got inr=%h ready=%b exp 00/1", inr, instr_ready); end
    adv();
    instr_valid = 1'b0;
    #1;
    n_cmp++; if (dcr !== 8'h20 || inr !== 8'h00) begin n_err++; $display("FAIL b2b_dcr: got dcr=%h inr=%h exp 20/00", dcr, inr); end
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_exec2: got %b exp 0", instr_ready); end
    adv();
    n_cmp++; if (retired !== 8'h02 || dcr !== 8'h00) begin n_err++; $display("FAIL b2b_retired: got %h dcr=%h exp 02/00", retired, dcr); end
  endtask

  task automatic test_mov();
    do_reset();
    rd_data = 8'hC3; instr_valid = 1'b1; instr_data = 8'h7A;
    adv();
    instr_valid = 1'b0;
    #1;
    n_cmp++; if (rd_sel !== 3'd2) begin n_err++; $display("FAIL mov_rd_sel: got %0d exp 2", rd_sel); end
    n_cmp++; if (load !== 8'h80) begin n_err++; $display("FAIL mov_load: got %h exp 80", load); end
    n_cmp++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL mov_data: got %h exp c3", data_out); end
    rd_data = 8'h3C;
    #1;
    n_cmp++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL mov_data_comb: got %h exp 3c", data_out); end
    adv();
    n_cmp++; if (load !== 8'h00 || data_out !== 8'h00) begin n_err++; $display("FAIL mov_after: got load=%h data=%h exp 00/00", load, data_out); end
    n_cmp++; if (rd_sel !== 3'd2 || retired !== 8'h01) begin n_err++; $display("FAIL mov_hold: got rd_sel=%0d retired=%h exp 2/01", rd_sel, retired); end
  endtask

  task automatic test_halt();
    do_reset();
    instr_valid = 1'b1; instr_data = 8'h76;
    adv();
    instr_data = 8'h04;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (halted !== 1'b1 || instr_ready !== 1'b0 || {load, inr, dcr} !== 24'h0 || retired !== 8'h01) begin
        n_err++;
        $display("FAIL halt_cycle%0d: got halted=%b ready=%b strobes=%h retired=%h exp 1/0/0/01", i, halted, instr_ready, {load, inr, dcr}, retired);
      end
      adv();
    end
    do_reset();
    n_cmp++; if (halted !== 1'b0 || retired !== 8'h00) begin n_err++; $display("FAIL halt_reset: got halted=%b retired=%h exp 0/00", halted, retired); end
  endtask

  task automatic test_illegal();
    do_reset();
    instr_valid = 1'b1; instr_data = 8'hC0;
    adv();
`ifdef SEQ_ILLEGAL_TRAP_EN
    instr_data = 8'h04;
    #1;
    n_cmp++; if (illegal !== 1'b1 || halted !== 1'b1) begin n_err++; $display("FAIL ill_trap: got illegal=%b halted=%b exp 1/1", illegal, halted); end
    n_cmp++; if (instr_ready !== 1'b0 || retired !== 8'h00) begin n_err++; $display("FAIL ill_trap_ready: got ready=%b retired=%h exp 0/00", instr_ready, retired); end
    adv(); adv();
    n_cmp++; if (illegal !== 1'b1 || inr !== 8'h00) begin n_err++; $display("FAIL ill_sticky: got illegal=%b inr=%h exp 1/00", illegal, inr); end
    do_reset();
    n_cmp++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL ill_reset: got illegal=%b halted=%b exp 0/0", illegal, halted); end
`else
    instr_data = 8'h04;
    #1;
    n_cmp++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL ill_noop: got illegal=%b halted=%b exp 0/0", illegal, halted); end
    n_cmp++; if (instr_ready !== 1'b1 || retired !== 8'h00 || {load, inr, dcr} !== 24'h0) begin n_err++; $display("FAIL ill_noop_state: got ready=%b retired=%h strobes=%h exp 1/00/0", instr_ready, retired, {load, inr, dcr}); end
    adv();
    instr_data = 8'h08;
    #1;
    n_cmp++; if (inr !== 8'h01) begin n_err++; $display("FAIL ill_next_inr: got %h exp 01", inr); end
    adv();
    instr_data = 8'h07;
    adv();
    instr_valid = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1 || {load, inr, dcr} !== 24'h0 || retired !== 8'h01 || illegal !== 1'b0) begin n_err++; $display("FAIL ill_more: got ready=%b strobes=%h retired=%h illegal=%b exp 1/0/01/0", instr_ready, {load, inr, dcr}, retired, illegal); end
`endif
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    instr_valid = 1'b1; instr_data = 8'h00;
    for (int c = 1; c <= 512; c++) begin
      adv();
      if (c == 1) begin
        n_cmp++; if ({load, inr, dcr, data_out} !== 32'h0 || instr_ready !== 1'b0) begin n_err++; $display("FAIL nop_exec: got strobes=%h ready=%b exp 0/0", {load, inr, dcr, data_out}, instr_ready); end
      end
      if (c == 510) begin
        n_cmp++; if (retired !== 8'hFF) begin n_err++; $display("FAIL wrap_ff: got %h exp ff", retired); end
      end
    end
    n_cmp++; if (retired !== 8'h00) begin n_err++; $display("FAIL wrap_00: got %h exp 00", retired); end
    do_reset();
    instr_valid = 1'b1; instr_data = 8'h0E;
    adv();
    rst = 1'b1; instr_data = 8'h5A;
    adv();
    rst = 1'b0; instr_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (load !== 8'h00 || retired !== 8'h00) begin n_err++; $display("FAIL abort_imm%0d: got load=%h retired=%h exp 00/00", i, load, retired); end
      adv();
    end
    instr_valid = 1'b1; instr_data = 8'h04;
    adv();
    rst = 1'b1; instr_valid = 1'b0;
    adv();
    rst = 1'b0;
    #1;
    n_cmp++; if (retired !== 8'h00 || instr_ready !== 1'b1 || inr !== 8'h00) begin n_err++; $display("FAIL abort_exec: got retired=%h ready=%b inr=%h exp 00/1/00", retired, instr_ready, inr); end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_back_to_back();
    test_mov();
    test_halt();
    test_illegal();
    test_wrap_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_sequencer.md
REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port instr_valid, input, 1 bit: instr_data carries an opcode or immediate byte.
REQ-004 SHALL have port instr_data, input, 8 bits: instruction byte stream.
REQ-005 SHALL have port instr_ready, output, 1 bit: sequencer accepts a byte this cycle.
REQ-006 SHALL have port rd_data, input, 8 bits: value of the register selected by rd_sel, from the bank.
REQ-007 SHALL have port rd_sel, output, 3 bits: source register index for MOV.
REQ-008 SHALL have ports load, inr and dcr, output, 8 bits each: one-hot per-register strobes to the register bank.
REQ-009 SHALL have port data_out, output, 8 bits: write data for the register bank.
REQ-010 SHALL have port halted, output, 1 bit: sequencer is in HALT.
REQ-011 SHALL have port illegal, output, 1 bit: sticky illegal-opcode flag.
REQ-012 SHALL have port retired, output, 8 bits: count of completed instructions.

Function
REQ-013 SHALL implement the states FETCH, IMM, EXEC and HALT.
REQ-014 SHALL define the decode set: 8'h00 NOP; 00_ddd_100 INR d; 00_ddd_101 DCR d; 00_ddd_110 MVI d,imm (2 bytes); 01_ddd_sss MOV d,s; 8'h76 HLT (takes priority over MOV 6,6); all other encodings illegal.
REQ-015 SHALL complete a byte transfer on a posedge with instr_valid=1 and instr_ready=1; instr_ready=1 only in FETCH and IMM.
REQ-016 SHALL, in FETCH on an accepted opcode: MVI -> IMM; INR/DCR/MOV/NOP -> EXEC; HLT -> HALT; illegal -> per REQ-027/028.
REQ-017 SHALL, in IMM on an accepted byte, latch it as the immediate and go to EXEC.
REQ-018 SHALL, in EXEC, for exactly one cycle, assert at most one strobe bit, then return to FETCH: MVI -> load[d]=1 and data_out=imm; MOV -> load[d]=1, rd_sel=s and data_out=rd_data (combinational in EXEC); INR -> inr[d]=1; DCR -> dcr[d]=1; NOP -> no strobe.
REQ-019 SHALL make the strobe latency one cycle after opcode acceptance (two cycles for MVI: opcode, immediate, then strobe); the sustained rate is one instruction per 2 cycles (3 for MVI).
REQ-020 SHALL hold load, inr and dcr at 0 outside EXEC, and hold data_out at 0 whenever load is 0.
REQ-021 SHALL hold rd_sel at the last latched source field outside EXEC (don't-care to the bank).
REQ-022 SHALL increment retired by 1 in EXEC and on HLT acceptance, and wrap 8'hFF -> 8'h00; illegal opcodes SHALL NOT increment it.
REQ-023 SHALL keep HALT absorbing: instr_ready=0, no strobes, and exit only by rst.
REQ-024 SHALL leave a byte presented while instr_ready=0 unconsumed; the upstream holds it.

Reset
REQ-025 SHALL, when rst=1 at a posedge, set state=FETCH and retired=0, clear illegal, halted and the latched fields, and set every strobe and data_out to 0 in the following cycle. The instruction input is ignored in that cycle.
REQ-026 SHALL, on a reset mid-operation (during IMM or EXEC), abort the instruction with no strobe issued and no retire count.

Configuration
REQ-027 SHALL, with SEQ_ILLEGAL_TRAP_EN defined, on an illegal opcode set illegal=1 (sticky until rst) and enter HALT.
REQ-028 SHALL, with SEQ_ILLEGAL_TRAP_EN undefined, consume an illegal opcode as a no-op (stay in FETCH, no strobe, no retire) and tie illegal to 0.

Verification
REQ-029 SHALL cover this scenario: rst 1 cycle, then stream 8'h0E (MVI 1), 8'h5A -> load=8'h02 and data_out=8'h5A for one cycle, two cycles after the opcode handshake; retired=1.
REQ-030 SHALL cover this scenario: 8'h04 (INR 0), then 8'h2D (DCR 5) back-to-back with instr_valid held -> inr=8'h01 pulse, then dcr=8'h20 pulse; instr_ready low during each EXEC; retired=2.
REQ-031 SHALL cover this scenario: 8'h7A (MOV 7,2) with rd_data=8'hC3 -> rd_sel=3'd2, load=8'h80 and data_out=8'hC3 in EXEC.
REQ-032 SHALL cover this scenario: 8'h76 -> halted=1 and instr_ready=0 for 10 or more cycles with valid held; rst -> halted=0 and retired=0.
REQ-033 SHALL cover this scenario: 8'hC0 (illegal) -> with SEQ_ILLEGAL_TRAP_EN: illegal=1, halted=1; without: next opcode 8'h04 executes normally and illegal=0.
REQ-034 SHALL cover this scenario: 256 NOPs -> retired wraps to 8'h00; an MVI opcode followed by rst in IMM -> no load pulse.
